mem_stage_lsu: RTL and testbench

Memory stage of the RV32I pipeline, directly downstream of the IF/ID/EX datapath. It registers the EX result (EX/MEM boundary), performs RV32I loads and stores against a request/grant/rvalid data-memory port with byte-lane alignment and sign/zero extension, and presents a one-cycle-valid writeback packet to the WB stage. While a memory access is outstanding it stalls EX through a ready signal.

---
 rtl/mem_stage_lsu_if.sv | 52 +++++
 rtl/mem_stage_lsu.sv | 197 +++++++++++++++++++
 tb/tb_mem_stage_lsu.sv | 346 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_lsu_if.sv
// Bundle of EX handoff, data-memory port and writeback packet
// for the RV32I memory stage.
interface mem_stage_lsu_if;
  logic        EX_valid;
  logic        EX_ready;
  logic [31:0] EX_ALU_result;
  logic [31:0] EX_rs2_data;
  logic [4:0]  EX_rd_addr;
  logic [2:0]  EX_funct3;
  logic        EX_mem_read;
  logic        EX_mem_write;
  logic        EX_reg_write;

  logic        DMEM_req;
  logic        DMEM_we;
  logic [31:0] DMEM_addr;
  logic [31:0] DMEM_wdata;
  logic [3:0]  DMEM_be;
  logic        DMEM_gnt;
  logic        DMEM_rvalid;
  logic [31:0] DMEM_rdata;

  logic        MEM_valid;
  logic [4:0]  MEM_rd_addr;
  logic        MEM_reg_write;
  logic [31:0] MEM_wb_data;
  logic        MEM_exception;

  modport master (
    input  EX_valid, EX_ALU_result, EX_rs2_data,
    input  EX_rd_addr, EX_funct3, EX_mem_read,
    input  EX_mem_write, EX_reg_write,
    input  DMEM_gnt, DMEM_rvalid, DMEM_rdata,
    output EX_ready,
    output DMEM_req, DMEM_we, DMEM_addr,
    output DMEM_wdata, DMEM_be,
    output MEM_valid, MEM_rd_addr, MEM_reg_write,
    output MEM_wb_data, MEM_exception
  );

  modport slave (
    output EX_valid, EX_ALU_result, EX_rs2_data,
    output EX_rd_addr, EX_funct3, EX_mem_read,
    output EX_mem_write, EX_reg_write,
    output DMEM_gnt, DMEM_rvalid, DMEM_rdata,
    input  EX_ready,
    input  DMEM_req, DMEM_we, DMEM_addr,
    input  DMEM_wdata, DMEM_be,
    input  MEM_valid, MEM_rd_addr, MEM_reg_write,
    input  MEM_wb_data, MEM_exception
  );
endinterface

// File: rtl/mem_stage_lsu.sv
// RV32I memory stage: EX/MEM register, load/store unit with
// req/gnt/rvalid port, lane alignment and writeback packet.
module mem_stage_lsu (
  input logic            Clk,
  input logic            Reset,
  mem_stage_lsu_if.master bus
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t state, state_nx;

  logic        ready;
  logic        accept;
  logic        is_mem;
  logic        misalign;
  logic        illegal;
  logic        fault;
  logic [1:0]  off;
  logic [2:0]  f3;
  logic [31:0] st_wdata;
  logic [3:0]  st_be;

  logic [31:0] ea_q;
  logic [1:0]  off_q;
  logic [2:0]  f3_q;
  logic [4:0]  rd_q;
  logic        rw_q;

  logic [31:0] shifted;
  logic [15:0] half;
  logic [31:0] ld_data;
  logic        done_st;
  logic        done_ld;

  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic        mvalid;
  logic [4:0]  mrd;
  logic        mrw;
  logic [31:0] mwb;
  logic        mexc;

  assign off    = bus.EX_ALU_result[1:0];
  assign f3     = bus.EX_funct3;
  assign is_mem = bus.EX_mem_read | bus.EX_mem_write;
  assign ready  = (state == IDLE);
  assign accept = bus.EX_valid & ready;
  assign req    = (state == REQ);

  always_comb begin
    misalign = 1'b0;
    case (f3[1:0])
      2'b01:   misalign = off[0];
      2'b10:   misalign = |off;
      default: misalign = 1'b0;
    endcase
  end

  // Loads allow 000,001,010,100,101; stores 000..010.
  always_comb begin
    illegal = 1'b0;
    if (bus.EX_mem_write)
      illegal = (f3 > 3'd2);
    else
      illegal = (f3 == 3'b011) | (f3[2:1] == 2'b11);
  end

  assign fault = is_mem & (misalign | illegal);

  always_comb begin
    st_wdata = bus.EX_rs2_data;
    st_be    = 4'b1111;
    case (f3[1:0])
      2'b00: begin
        st_wdata = {4{bus.EX_rs2_data[7:0]}};
        st_be    = 4'b0001 << off;
      end
      2'b01: begin
        st_wdata = {2{bus.EX_rs2_data[15:0]}};
        st_be    = off[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
  end

  assign shifted = bus.DMEM_rdata >> {off_q, 3'b000};
  assign half    = off_q[1] ? bus.DMEM_rdata[31:16]
                            : bus.DMEM_rdata[15:0];

  always_comb begin
    ld_data = bus.DMEM_rdata;
    case (f3_q)
      3'b000:  ld_data = {{24{shifted[7]}}, shifted[7:0]};
      3'b100:  ld_data = {24'b0, shifted[7:0]};
      3'b001:  ld_data = {{16{half[15]}}, half};
      3'b101:  ld_data = {16'b0, half};
      default: ld_data = bus.DMEM_rdata;
    endcase
  end

  assign done_st = req & bus.DMEM_gnt & we;
  assign done_ld = (state == WAIT) & bus.DMEM_rvalid;

  always_ff @(posedge Clk) begin
    if (Reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:
        if (accept && is_mem && !fault)
          state_nx = REQ;
      REQ:
        if (bus.DMEM_gnt)
          state_nx = we ? IDLE : WAIT;
      WAIT:
        if (bus.DMEM_rvalid)
          state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      ea_q   <= '0;
      off_q  <= '0;
      f3_q   <= '0;
      rd_q   <= '0;
      rw_q   <= 1'b0;
      we     <= 1'b0;
      addr   <= '0;
      wdata  <= '0;
      be     <= '0;
      mvalid <= 1'b0;
      mrd    <= '0;
      mrw    <= 1'b0;
      mwb    <= '0;
      mexc   <= 1'b0;
    end else begin
      mvalid <= 1'b0;
      if (accept) begin
        if (is_mem && !fault) begin
          ea_q  <= bus.EX_ALU_result;
          off_q <= off;
          f3_q  <= f3;
          rd_q  <= bus.EX_rd_addr;
          rw_q  <= bus.EX_reg_write
                 & bus.EX_mem_read
                 & (|bus.EX_rd_addr);
          we    <= bus.EX_mem_write;
          addr  <= {bus.EX_ALU_result[31:2], 2'b00};
          wdata <= bus.EX_mem_write ? st_wdata : '0;
          be    <= bus.EX_mem_write ? st_be : 4'b0000;
        end else begin
          mvalid <= 1'b1;
          mrd    <= bus.EX_rd_addr;
          mrw    <= bus.EX_reg_write
                  & !is_mem
                  & (|bus.EX_rd_addr);
          mwb    <= bus.EX_ALU_result;
          mexc   <= fault;
        end
      end
      if (done_st) begin
        mvalid <= 1'b1;
        mrd    <= rd_q;
        mrw    <= 1'b0;
        mwb    <= ea_q;
        mexc   <= 1'b0;
      end
      if (done_ld) begin
        mvalid <= 1'b1;
        mrd    <= rd_q;
        mrw    <= rw_q;
        mwb    <= ld_data;
        mexc   <= 1'b0;
      end
    end
  end

  assign bus.EX_ready      = ready;
  assign bus.DMEM_req      = req;
  assign bus.DMEM_we       = we;
  assign bus.DMEM_addr     = addr;
  assign bus.DMEM_wdata    = wdata;
  assign bus.DMEM_be       = be;
  assign bus.MEM_valid     = mvalid;
  assign bus.MEM_rd_addr   = mrd;
  assign bus.MEM_reg_write = mrw;
  assign bus.MEM_wb_data   = mwb;
  assign bus.MEM_exception = mexc;
endmodule

// File: tb/tb_mem_stage_lsu.sv
// Bench for mem_stage_lsu: directed table, corner sequences
// and random ops against a behavioural model.
`timescale 1ns/1ps
module tb_mem_stage_lsu;
  logic Clk = 1'b0;
  logic Reset = 1'b1;

  mem_stage_lsu_if bus();

  mem_stage_lsu dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int fails  = 0;

  typedef struct {
    logic [31:0] alu;
    logic [31:0] rs2;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic        ld;
    logic        st;
    logic        rw;
    int          gd;
    int          rvd;
    logic [31:0] rdata;
    logic [31:0] ewb;
    logic        erw;
    logic        eexc;
    logic [3:0]  ebe;
    logic [31:0] ewd;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic vec_t mk(
    input logic [31:0] alu, input logic [31:0] rs2,
    input logic [4:0] rd, input logic [2:0] f3,
    input logic ld, input logic st, input logic rw,
    input int gd, input int rvd, input logic [31:0] rdata,
    input logic [31:0] ewb, input logic erw,
    input logic eexc, input logic [3:0] ebe,
    input logic [31:0] ewd);
    vec_t v;
    v.alu = alu; v.rs2 = rs2; v.rd = rd; v.f3 = f3;
    v.ld = ld; v.st = st; v.rw = rw;
    v.gd = gd; v.rvd = rvd; v.rdata = rdata;
    v.ewb = ewb; v.erw = erw; v.eexc = eexc;
    v.ebe = ebe; v.ewd = ewd;
    return v;
  endfunction

  // Reference behaviour from the ISA rules, in plain arithmetic.
  function automatic void model(
    input vec_t v,
    output logic [31:0] wb, output logic rw,
    output logic exc, output logic [3:0] be,
    output logic [31:0] wd, output int lat,
    output int nreq);
    int a;
    int size;
    bit legal;
    logic [31:0] mask;
    logic [31:0] field;
    a = int'(v.alu % 4);
    wb = v.alu; rw = 1'b0; exc = 1'b0;
    be = 4'b0000; wd = '0; lat = 1; nreq = 0;
    if (!v.ld && !v.st) begin
      rw = v.rw && (v.rd != 0);
      return;
    end
    size = (v.f3[1:0] == 2'd0) ? 1 :
           (v.f3[1:0] == 2'd1) ? 2 : 4;
    if (v.st) legal = (v.f3 <= 3'd2);
    else      legal = v.f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    if (!legal || (a % size) != 0) begin
      exc = 1'b1;
      return;
    end
    nreq = v.gd + 1;
    if (v.st) begin
      be = 4'((1 << size) - 1) << a;
      if (size == 1)      wd = v.rs2[7:0] * 32'h01010101;
      else if (size == 2) wd = v.rs2[15:0] * 32'h00010001;
      else                wd = v.rs2;
      lat = v.gd + 2;
    end else begin
      mask = (size == 4) ? 32'hFFFF_FFFF
                         : (32'd1 << (8 * size)) - 1;
      field = (v.rdata >> (8 * a)) & mask;
      if (v.f3[2] == 1'b0 && size < 4 && field[8*size-1])
        field = field | ~mask;
      wb = field;
      rw = v.rw && (v.rd != 0);
      lat = v.gd + v.rvd + 3;
    end
  endfunction

  task automatic idle_inputs();
    bus.EX_valid = 1'b0;
    bus.EX_ALU_result = '0;
    bus.EX_rs2_data = '0;
    bus.EX_rd_addr = '0;
    bus.EX_funct3 = '0;
    bus.EX_mem_read = 1'b0;
    bus.EX_mem_write = 1'b0;
    bus.EX_reg_write = 1'b0;
    bus.DMEM_gnt = 1'b0;
    bus.DMEM_rvalid = 1'b0;
    bus.DMEM_rdata = '0;
  endtask

  task automatic drive_ex(input vec_t v);
    bus.EX_valid = 1'b1;
    bus.EX_ALU_result = v.alu;
    bus.EX_rs2_data = v.rs2;
    bus.EX_rd_addr = v.rd;
    bus.EX_funct3 = v.f3;
    bus.EX_mem_read = v.ld;
    bus.EX_mem_write = v.st;
    bus.EX_reg_write = v.rw;
  endtask

  task automatic run(input vec_t v, input string tag,
                     input bit use_tbl);
    logic [31:0] mwb, mwd, g_wb, a0, w0;
    logic        mrw, mexc, g_rw, g_exc, we0;
    logic [3:0]  mbe, b0;
    logic [4:0]  g_rd;
    int lat, nreq;
    int pulses, seen, reqs, rdy_bad, stab_bad, rvc;
    bit granted, rvp;
    pulses = 0; seen = -1; reqs = 0;
    rdy_bad = 0; stab_bad = 0; rvc = 0;
    granted = 0; rvp = 0;
    g_wb = 'x; g_rw = 'x; g_exc = 'x; g_rd = 'x;
    a0 = 'x; w0 = 'x; b0 = 'x; we0 = 1'b0;
    model(v, mwb, mrw, mexc, mbe, mwd, lat, nreq);
    if (use_tbl) begin
      mwb = v.ewb; mrw = v.erw; mexc = v.eexc;
      if (v.st) begin mbe = v.ebe; mwd = v.ewd; end
    end
    @(negedge Clk);
    chk({tag, " ready_at_issue"}, 32'(bus.EX_ready), 1);
    drive_ex(v);
    for (int k = 1; k <= 60; k++) begin
      @(negedge Clk);
      if (k == 1) bus.EX_valid = 1'b0;
      if (bus.EX_ready !== (k >= lat)) rdy_bad++;
      if (bus.MEM_valid === 1'b1) begin
        pulses++;
        if (seen < 0) begin
          seen = k;
          g_wb = bus.MEM_wb_data;
          g_rd = bus.MEM_rd_addr;
          g_rw = bus.MEM_reg_write;
          g_exc = bus.MEM_exception;
        end
      end
      bus.DMEM_gnt = 1'b0;
      bus.DMEM_rvalid = 1'b0;
      bus.DMEM_rdata = $urandom();
      if (rvp) begin
        if (rvc == v.rvd) begin
          bus.DMEM_rvalid = 1'b1;
          bus.DMEM_rdata = v.rdata;
          rvp = 0;
        end
        rvc++;
      end
      if (bus.DMEM_req === 1'b1) begin
        reqs++;
        if (!granted) begin
          if (reqs == 1) begin
            a0 = bus.DMEM_addr; w0 = bus.DMEM_wdata;
            b0 = bus.DMEM_be; we0 = bus.DMEM_we;
          end else if (a0 !== bus.DMEM_addr ||
                       w0 !== bus.DMEM_wdata ||
                       b0 !== bus.DMEM_be ||
                       we0 !== bus.DMEM_we)
            stab_bad++;
          if (reqs > v.gd) begin
            bus.DMEM_gnt = 1'b1;
            granted = 1;
            rvp = !we0;
            rvc = 0;
          end
        end
      end
      if (seen > 0 && k >= seen + 1) break;
    end
    bus.DMEM_gnt = 1'b0;
    bus.DMEM_rvalid = 1'b0;
    chk({tag, " pulses"}, 32'(pulses), 1);
    chk({tag, " latency"}, 32'(seen), 32'(lat));
    chk({tag, " wb_data"}, g_wb, mwb);
    chk({tag, " rd_addr"}, 32'(g_rd), 32'(v.rd));
    chk({tag, " reg_write"}, 32'(g_rw), 32'(mrw));
    chk({tag, " exception"}, 32'(g_exc), 32'(mexc));
    chk({tag, " req_cycles"}, 32'(reqs), 32'(nreq));
    chk({tag, " ready_profile"}, 32'(rdy_bad), 0);
    if (nreq > 0) begin
      chk({tag, " addr"}, a0, v.alu & ~32'd3);
      chk({tag, " we"}, 32'(we0), 32'(v.st));
      chk({tag, " be"}, 32'(b0), 32'(mbe));
      chk({tag, " req_stable"}, 32'(stab_bad), 0);
      if (v.st) chk({tag, " wdata"}, w0, mwd);
    end
  endtask

  initial begin
    vec_t v;
    int bad;
    idle_inputs();
    Reset = 1'b1;
    repeat (3) @(negedge Clk);
    chk("rst ready", 32'(bus.EX_ready), 1);
    chk("rst ctrl", 32'({bus.DMEM_req, bus.DMEM_we,
        bus.MEM_valid, bus.MEM_reg_write,
        bus.MEM_exception}), 0);
    chk("rst data", bus.DMEM_addr | bus.DMEM_wdata |
        bus.MEM_wb_data, 0);
    chk("rst be_rd", 32'({bus.DMEM_be, bus.MEM_rd_addr}), 0);
    Reset = 1'b0;

    // Three back-to-back ALU ops, one result per cycle.
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk);
      if (i >= 1 && i <= 3) begin
        chk($sformatf("b2b%0d valid", i), 32'(bus.MEM_valid), 1);
        chk($sformatf("b2b%0d wb", i), bus.MEM_wb_data, 32'(i));
        chk($sformatf("b2b%0d rd", i), 32'(bus.MEM_rd_addr),
            32'(4 + i));
        chk($sformatf("b2b%0d rw", i), 32'(bus.MEM_reg_write), 1);
      end
      if (i == 4) chk("b2b tail valid", 32'(bus.MEM_valid), 0);
      chk($sformatf("b2b%0d ready", i), 32'(bus.EX_ready), 1);
      if (i < 3) begin
        v = mk(32'(i + 1), 0, 5'(5 + i), 0, 0, 0, 1,
               0, 0, 0, 0, 0, 0, 0, 0);
        drive_ex(v);
      end else bus.EX_valid = 1'b0;
    end

    //     alu          rs2          rd f3 ld st rw gd rv rdata
    //     ewb          erw exc be     wdata
    tbl.push_back(mk(32'h1003, 32'hA5, 4, 3'd0, 0, 1, 0, 2, 0, 0,
      32'h1003, 0, 0, 4'b1000, 32'hA5A5A5A5));
    tbl.push_back(mk(32'h2002, 0, 10, 3'd0, 1, 0, 1, 0, 0,
      32'h0080_0000, 32'hFFFFFF80, 1, 0, 0, 0));
    tbl.push_back(mk(32'h2002, 0, 11, 3'd4, 1, 0, 1, 1, 1,
      32'h0080_0000, 32'h00000080, 1, 0, 0, 0));
    tbl.push_back(mk(32'h2002, 0, 12, 3'd1, 1, 0, 1, 0, 2,
      32'h8001_0000, 32'hFFFF8001, 1, 0, 0, 0));
    tbl.push_back(mk(32'h2002, 0, 13, 3'd5, 1, 0, 1, 0, 0,
      32'h8001_0000, 32'h00008001, 1, 0, 0, 0));
    tbl.push_back(mk(32'h3002, 0, 14, 3'd2, 1, 0, 1, 0, 0, 0,
      32'h3002, 0, 1, 0, 0));
    tbl.push_back(mk(32'h4000, 0, 0, 3'd2, 1, 0, 1, 0, 0,
      32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 0, 0));
    tbl.push_back(mk(32'h5002, 32'h1234ABCD, 3, 3'd1, 0, 1, 0,
      1, 0, 0, 32'h5002, 0, 0, 4'b1100, 32'hABCDABCD));
    tbl.push_back(mk(32'h6000, 32'hCAFEF00D, 3, 3'd2, 0, 1, 0,
      0, 0, 0, 32'h6000, 0, 0, 4'b1111, 32'hCAFEF00D));
    tbl.push_back(mk(32'h5001, 32'h1, 3, 3'd1, 0, 1, 0, 0, 0, 0,
      32'h5001, 0, 1, 0, 0));
    tbl.push_back(mk(32'h7000, 32'h1, 3, 3'd3, 0, 1, 0, 0, 0, 0,
      32'h7000, 0, 1, 0, 0));
    tbl.push_back(mk(32'h7004, 0, 9, 3'd6, 1, 0, 1, 0, 0, 0,
      32'h7004, 0, 1, 0, 0));
    tbl.push_back(mk(32'h2001, 0, 8, 3'd0, 1, 0, 1, 3, 2,
      32'h0000_7F00, 32'h0000007F, 1, 0, 0, 0));
    tbl.push_back(mk(32'h1234, 0, 0, 3'd0, 0, 0, 1, 0, 0, 0,
      32'h1234, 0, 0, 0, 0));
    foreach (tbl[i]) run(tbl[i], $sformatf("tbl%0d", i), 1);

    // Reset while a load waits for rvalid; late rvalid ignored.
    @(negedge Clk);
    v = mk(32'h8000, 0, 3, 3'd2, 1, 0, 1, 0, 0, 0,
           0, 0, 0, 0, 0);
    drive_ex(v);
    @(negedge Clk);
    bus.EX_valid = 1'b0;
    chk("rstw req", 32'(bus.DMEM_req), 1);
    bus.DMEM_gnt = 1'b1;
    @(negedge Clk);
    bus.DMEM_gnt = 1'b0;
    chk("rstw wait_ready", 32'(bus.EX_ready), 0);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    chk("rstw ready", 32'(bus.EX_ready), 1);
    chk("rstw req_off", 32'(bus.DMEM_req), 0);
    bus.DMEM_rvalid = 1'b1;
    bus.DMEM_rdata = 32'h12345678;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge Clk);
      bus.DMEM_rvalid = 1'b0;
      if (bus.MEM_valid !== 1'b0 || bus.DMEM_req !== 1'b0 ||
          bus.EX_ready !== 1'b1)
        bad++;
    end
    chk("rstw quiet", 32'(bad), 0);
    run(mk(32'h55, 0, 6, 0, 0, 0, 1, 0, 0, 0, 32'h55, 1, 0, 0, 0),
        "rstw alu", 1);

    // Random ops against the model.
    for (int n = 0; n < 150; n++) begin
      int cls;
      cls = $urandom_range(0, 2);
      v = mk($urandom(), $urandom(), 5'($urandom()),
             3'($urandom()), cls == 1, cls == 2,
             1'($urandom()), $urandom_range(0, 3),
             $urandom_range(0, 3), $urandom(),
             0, 0, 0, 0, 0);
      if ($urandom_range(0, 3) != 0) begin
        if (cls == 1) v.f3 = (v.f3 == 3'd3) ? 3'd2 :
                             (v.f3[2:1] == 2'b11) ? 3'd4 : v.f3;
        if (cls == 2 && v.f3 > 3'd2) v.f3 = 3'(v.f3 % 3);
        if (v.f3[1]) v.alu[1:0] = 2'b00;
        else if (v.f3[0]) v.alu[0] = 1'b0;
      end
      run(v, $sformatf("rnd%0d", n), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end
endmodule
